multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the single-cycle CPU datapath rebuilt around one shared ALU and one unified memory port. The FSM sequences every instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the mux selects and write enables for PC, IR, register file, ALU and memory. It stalls on a memory-ready handshake and halts on illegal opcodes.

## Interface
- No parameters.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- opcode_i  in  6  instr[31:26] from datapath IR.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  unconditional PC load.
- branch_o  out  1  conditional PC load. The datapath loads the PC when (branch_eq_o ? zero : ~zero) & branch_o.
- branch_eq_o  out  1  1 for beq, 0 for bne.
- pc_source_o  out  2  PC mux select: 00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28], instr[25:0], 2'b00}.
- ir_write_o  out  1  latch memory data into IR.
- iord_o  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- reg_write_o  out  1  register file write.
- reg_dst_o  out  1  destination register: 0 rt, 1 rd.
- mem_to_reg_o  out  1  write-data select: 0 ALUOut, 1 MDR.
- alu_src_a_o  out  1  ALU A input: 0 PC, 1 RS.
- alu_src_b_o  out  2  ALU B input: 00 RT, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- alu_op_o  out  3  to ALU_Ctrl: 000 add, 001 sub, 010 R-type (use funct), 011 slt.
- state_o  out  4  current state, for debug and bench.
- halted_o  out  1  sticky illegal-opcode flag.

## Operation
State encoding:
- 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC, 7 R_WB, 8 BRANCH, 9 JUMP, 10 I_EXEC, 11 I_WB, 12 HALT.

Default outputs:
- Every output not listed for a state is 0.

Per-state behaviour:
- FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000, pc_source_o=00.
  - ir_write_o and pc_write_o equal mem_ready_i (Mealy gating).
  - Go to DECODE when mem_ready_i=1, else stay in FETCH.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000, so ALUOut holds the branch target. Latch opcode_i into op_q.
  - opcode 0x00 → R_EXEC.
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR.
  - 0x04 (beq) or 0x05 (bne) → BRANCH.
  - 0x02 (j) → JUMP.
  - 0x08 (addi) or 0x0A (slti) → I_EXEC.
  - Any other opcode → HALT.
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000. Go to MEM_RD if op_q=0x23, else MEM_WR.
- MEM_RD: mem_read_o=1, iord_o=1. Stay until mem_ready_i=1, then go to MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1. Go to FETCH.
- MEM_WR: mem_write_o=1, iord_o=1. Stay until mem_ready_i=1, then go to FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=010. Go to R_WB.
- R_WB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0. Go to FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, branch_o=1, branch_eq_o=(op_q==0x04), pc_source_o=01. Go to FETCH.
- JUMP: pc_write_o=1, pc_source_o=10. Go to FETCH.
- I_EXEC: alu_src_a_o=1, alu_src_b_o=10, alu_op_o = 000 for addi, 011 for slti. Go to I_WB.
- I_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0. Go to FETCH.
- HALT: all outputs 0 and halted_o=1. Stays in HALT until reset.

Invariants:
- mem_read_o and mem_write_o are never 1 in the same cycle.
- At most one of pc_write_o or branch_o is 1 in any cycle.

## Timing
- Reset: rst_i low forces state=FETCH, op_q=0 and halted_o=0 immediately, without waiting for a clock edge.
- While rst_i is low, every output is forced to 0, including mem_read_o.
- The first FETCH request appears in the same cycle that rst_i goes high.
- Reset during any state, including a stalled MEM_RD or MEM_WR, abandons the access with no write enable asserted.
- Latency with mem_ready_i=1 every cycle:
  - R-type 4 cycles.
  - lw 5 cycles.
  - sw 4 cycles.
  - beq/bne 3 cycles.
  - j 3 cycles.
  - addi/slti 4 cycles.
- Each cycle of mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready_i is ignored in every other state.
- A mem_ready_i pulse arriving before a request state does not carry over into it.
- opcode_i is sampled only in DECODE. Changes to opcode_i in later states have no effect.

## Test plan
- R-type: reset release, opcode_i=0x00, mem_ready_i=1.
  - state_o follows 0,1,6,7,0.
  - alu_op_o=010 in state 6.
  - reg_write_o=1 and reg_dst_o=1 in state 7 only.
- lw with stall: opcode_i=0x23, mem_ready_i low for 2 cycles in MEM_RD.
  - state_o follows 0,1,2,3,3,3,4,0 (7 cycles).
  - mem_to_reg_o=1 in state 4.
  - mem_write_o never asserted.
- Branch: beq (0x04), then bne (0x05).
  - state_o follows 0,1,8,0 for each.
  - branch_o=1, alu_op_o=001 and pc_source_o=01 in state 8.
  - branch_eq_o=1 for beq, 0 for bne.
- Fetch stall: mem_ready_i=0 for 3 cycles in FETCH.
  - ir_write_o and pc_write_o stay 0 until mem_ready_i rises.
  - Both pulse for exactly 1 cycle, then state goes to DECODE.
- Illegal opcode 0x3F.
  - State goes to 12 and halted_o=1.
  - Both persist for 20 cycles of any stimulus.
  - A rst_i low pulse clears both; state_o=0.
- Reset mid-access: assert rst_i low while in MEM_WR with mem_ready_i=0.
  - mem_write_o drops to 0 before the next clock edge.
  - After release, state_o=0 and mem_read_o=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle CPU datapath built around one shared ALU and
// one unified memory port. Every instruction walks through fetch, decode and
// then an opcode-specific sequence of execute / memory / writeback states.
// Each cycle the FSM drives the datapath mux selects and write enables.
// Memory accesses stall on mem_ready_i; an unknown opcode parks the FSM in
// HALT until reset.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-low reset
//   opcode_i     in   instr[31:26] from the IR (sampled only in DECODE)
//   mem_ready_i  in   memory completes the current access this cycle
//   pc_write_o   out  unconditional PC load
//   branch_o     out  conditional PC load (qualified by zero in datapath)
//   branch_eq_o  out  1 = beq, 0 = bne
//   pc_source_o  out  PC mux: 00 ALU, 01 ALUOut, 10 jump target
//   ir_write_o   out  latch memory data into IR
//   iord_o       out  memory address: 0 PC, 1 ALUOut
//   mem_read_o   out  memory read request
//   mem_write_o  out  memory write request
//   reg_write_o  out  register file write
//   reg_dst_o    out  destination: 0 rt, 1 rd
//   mem_to_reg_o out  write data: 0 ALUOut, 1 MDR
//   alu_src_a_o  out  ALU A: 0 PC, 1 RS
//   alu_src_b_o  out  ALU B: 00 RT, 01 4, 10 imm, 11 imm<<2
//   alu_op_o     out  000 add, 001 sub, 010 R-type, 011 slt
//   state_o      out  current state (debug)
//   halted_o     out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       branch_eq_o,
    output logic [1:0] pc_source_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       halted_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t     state_q;
    logic [5:0] op_q;

    // State register. opcode_i is only looked at in DECODE; later states use
    // the latched copy so a changing IR cannot redirect an instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready_i) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode_i;
                    case (opcode_i)
                        OP_RTYPE:        state_q <= S_R_EXEC;
                        OP_LW, OP_SW:    state_q <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_q <= S_BRANCH;
                        OP_J:            state_q <= S_JUMP;
                        OP_ADDI, OP_SLTI: state_q <= S_I_EXEC;
                        default:         state_q <= S_HALT;
                    endcase
                end
                S_MEM_ADDR: state_q <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready_i) state_q <= S_MEM_WB;
                end
                S_MEM_WB:  state_q <= S_FETCH;
                S_MEM_WR: begin
                    if (mem_ready_i) state_q <= S_FETCH;
                end
                S_R_EXEC:  state_q <= S_R_WB;
                S_R_WB:    state_q <= S_FETCH;
                S_BRANCH:  state_q <= S_FETCH;
                S_JUMP:    state_q <= S_FETCH;
                S_I_EXEC:  state_q <= S_I_WB;
                S_I_WB:    state_q <= S_FETCH;
                S_HALT:    state_q <= S_HALT;
                default:   state_q <= S_HALT;
            endcase
        end
    end

    // Output decode. Outputs are a function of the registered state, except
    // that FETCH gates IR/PC writes with mem_ready_i so the PC only advances
    // on the cycle the instruction word actually arrives. Everything is
    // qualified with rst_i so a reset mid-access drops requests and write
    // enables immediately rather than at the next edge.
    always_comb begin
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        branch_eq_o  = 1'b0;
        pc_source_o  = 2'b00;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        halted_o     = 1'b0;
        if (rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                // PC + (imm << 2) computed speculatively: ALUOut then holds
                // the branch target for BRANCH.
                S_DECODE: alu_src_b_o = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b010;
                end
                S_R_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b001;
                    branch_o    = 1'b1;
                    branch_eq_o = (op_q == OP_BEQ);
                    pc_source_o = 2'b01;
                end
                S_JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'b10;
                end
                S_I_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = (op_q == OP_SLTI) ? 3'b011 : 3'b000;
                end
                S_I_WB:  reg_write_o = 1'b1;
                S_HALT:  halted_o    = 1'b1;
                default: halted_o    = 1'b0;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven directed vectors,
// hand-written reset/halt sequences, and randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       ready;
    logic       pc_write, branch, branch_eq, ir_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .mem_ready_i(ready),
        .pc_write_o(pc_write), .branch_o(branch), .branch_eq_o(branch_eq),
        .pc_source_o(pc_source), .ir_write_o(ir_write), .iord_o(iord),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .reg_write_o(reg_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .state_o(state),
        .halted_o(halted)
    );

    logic [18:0] ctl_dut;
    assign ctl_dut = {pc_write, branch, branch_eq, pc_source, ir_write, iord,
                      mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, alu_op, halted};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Control word the spec prescribes for a state, given the instruction's
    // opcode and the current mem_ready level.
    function automatic logic [18:0] ctl_of(input int st, input logic [5:0] op, input logic rdy);
        logic pcw, br, beq, irw, io, mr, mw, rw, rd, m2r, asa, hl;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        {pcw, br, beq, irw, io, mr, mw, rw, rd, m2r, asa, hl} = '0;
        ps = 2'b00; asb = 2'b00; aop = 3'b000;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 3'b001; br = 1; beq = (op == 6'h04); ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = (op == 6'h0A) ? 3'b011 : 3'b000; end
            11: rw = 1;
            12: hl = 1;
            default: hl = 0;
        endcase
        return {pcw, br, beq, ps, irw, io, mr, mw, rw, rd, m2r, asa, asb, aop, hl};
    endfunction

    // Phase list of an instruction (ignoring stalls); -1 marks the end.
    function automatic int phase_at(input logic [5:0] op, input int i);
        int p[6];
        case (op)
            6'h00:        p = '{0, 1, 6, 7, -1, -1};
            6'h23:        p = '{0, 1, 2, 3, 4, -1};
            6'h2B:        p = '{0, 1, 2, 5, -1, -1};
            6'h04, 6'h05: p = '{0, 1, 8, -1, -1, -1};
            6'h02:        p = '{0, 1, 9, -1, -1, -1};
            6'h08, 6'h0A: p = '{0, 1, 10, 11, -1, -1};
            default:      p = '{0, 1, 12, -1, -1, -1};
        endcase
        return p[i];
    endfunction

    task automatic drive(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = op;
        ready  = rdy;
        #1;
    endtask

    task automatic check_cycle(input string nm, input int st, input logic [5:0] op, input logic rdy);
        chk({nm, "_state"}, 32'(state), 32'(st));
        chk({nm, "_ctl"}, 32'(ctl_dut), 32'(ctl_of(st, op, rdy)));
        chk({nm, "_rdwr_excl"}, 32'(mem_read & mem_write), 32'd0);
        chk({nm, "_pc_excl"}, 32'(pc_write & branch), 32'd0);
    endtask

    typedef struct {
        logic [5:0] opc;
        logic       rdy;
        int         st;
        logic       pcw, irw, mr, mw, rw, beq;
        logic [2:0] aop;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // {opc, rdy, state, pc_write, ir_write, mem_read, mem_write, reg_write, branch_eq, alu_op}
        // R-type
        tbl.push_back('{6'h00, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 1, 6, 0, 0, 0, 0, 0, 0, 3'b010});
        tbl.push_back('{6'h00, 1, 7, 0, 0, 0, 0, 1, 0, 3'b000});
        // lw with two stall cycles in MEM_RD
        tbl.push_back('{6'h23, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 1, 2, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 0, 3, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 0, 3, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 1, 3, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h23, 1, 4, 0, 0, 0, 0, 1, 0, 3'b000});
        // beq then bne
        tbl.push_back('{6'h04, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h04, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h04, 1, 8, 0, 0, 0, 0, 0, 1, 3'b001});
        tbl.push_back('{6'h05, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h05, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h05, 1, 8, 0, 0, 0, 0, 0, 0, 3'b001});
        // fetch stall for 3 cycles, then an R-type
        tbl.push_back('{6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h00, 1, 6, 0, 0, 0, 0, 0, 0, 3'b010});
        tbl.push_back('{6'h00, 1, 7, 0, 0, 0, 0, 1, 0, 3'b000});
        // sw
        tbl.push_back('{6'h2B, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h2B, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h2B, 1, 2, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h2B, 1, 5, 0, 0, 0, 1, 0, 0, 3'b000});
        // j
        tbl.push_back('{6'h02, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h02, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000});
        tbl.push_back('{6'h02, 1, 9, 1, 0, 0, 0, 0, 0, 3'b000});

        // Reset state: every output forced low, even with mem_ready high.
        rst_n = 1'b0; opcode = 6'h00; ready = 1'b1;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl", 32'(ctl_dut), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Directed table (first drive releases reset).
        foreach (tbl[i]) begin
            drive(tbl[i].opc, tbl[i].rdy);
            chk("tbl_state", 32'(state), 32'(tbl[i].st));
            chk("tbl_pcw", 32'(pc_write), 32'(tbl[i].pcw));
            chk("tbl_irw", 32'(ir_write), 32'(tbl[i].irw));
            chk("tbl_mr", 32'(mem_read), 32'(tbl[i].mr));
            chk("tbl_mw", 32'(mem_write), 32'(tbl[i].mw));
            chk("tbl_rw", 32'(reg_write), 32'(tbl[i].rw));
            chk("tbl_beq", 32'(branch_eq), 32'(tbl[i].beq));
            chk("tbl_aop", 32'(alu_op), 32'(tbl[i].aop));
            chk("tbl_ctl", 32'(ctl_dut), 32'(ctl_of(tbl[i].st, tbl[i].opc, tbl[i].rdy)));
        end

        // Randomized instruction stream against the phase-list model.
        begin
            logic [5:0] legal[9];
            legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h00};
            for (int k = 0; k < 150; k++) begin
                logic [5:0] op;
                int ph;
                int cycles;
                op = legal[$urandom_range(0, 8)];
                ph = 0;
                cycles = 0;
                while (phase_at(op, ph) >= 0 && cycles < 200) begin
                    int st;
                    logic rdy;
                    st  = phase_at(op, ph);
                    rdy = ($urandom_range(0, 3) != 0);
                    drive((st == 1) ? op : 6'($urandom_range(0, 63)), rdy);
                    check_cycle("rnd", st, op, rdy);
                    if (!((st == 0 || st == 3 || st == 5) && !rdy)) ph++;
                    cycles++;
                end
                chk("rnd_bound", 32'(cycles < 200), 32'd1);
            end
        end

        // Reset while a store is stalled in MEM_WR.
        drive(6'h2B, 1); check_cycle("swr", 0, 6'h2B, 1);
        drive(6'h2B, 1); check_cycle("swr", 1, 6'h2B, 1);
        drive(6'h2B, 1); check_cycle("swr", 2, 6'h2B, 1);
        drive(6'h2B, 0); check_cycle("swr", 5, 6'h2B, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("swr_rst_mw", 32'(mem_write), 32'd0);
        chk("swr_rst_state", 32'(state), 32'd0);
        chk("swr_rst_ctl", 32'(ctl_dut), 32'd0);
        drive(6'h00, 1); check_cycle("swr_rel", 0, 6'h00, 1);
        chk("swr_rel_mr", 32'(mem_read), 32'd1);
        drive(6'h00, 1); check_cycle("swr_rel", 1, 6'h00, 1);
        drive(6'h00, 1); check_cycle("swr_rel", 6, 6'h00, 1);
        drive(6'h00, 1); check_cycle("swr_rel", 7, 6'h00, 1);

        // Illegal opcode: sticky HALT under random stimulus, cleared by reset.
        drive(6'h3F, 1); check_cycle("ill", 0, 6'h3F, 1);
        drive(6'h3F, 1); check_cycle("ill", 1, 6'h3F, 1);
        for (int c = 0; c < 20; c++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            drive(6'($urandom_range(0, 63)), r);
            check_cycle("halt", 12, 6'h3F, r);
            chk("halt_flag", 32'(halted), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_flag", 32'(halted), 32'd0);
        drive(6'h08, 1); check_cycle("post_halt", 0, 6'h08, 1);
        drive(6'h08, 1); check_cycle("post_halt", 1, 6'h08, 1);
        drive(6'h08, 1); check_cycle("post_halt", 10, 6'h08, 1);
        drive(6'h08, 1); check_cycle("post_halt", 11, 6'h08, 1);
        drive(6'h00, 1); check_cycle("post_halt", 0, 6'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
